wavelet_fir_dec: RTL and testbench



---
 rtl/wavelet_fir_dec.sv | 186 ++++++++++++++++++
 tb/tb_wavelet_fir_dec.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wavelet_fir_dec.sv
// rtl/wavelet_fir_dec.sv - decimating two-bank wavelet analysis FIR with a single time-multiplexed MAC
module wavelet_fir_dec #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 9,
    parameter int TAPS   = 8,
    parameter int DECIM  = 2,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic signed [DATA_W-1:0]  data_in,
    input  logic                      data_in_ready,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic                      clear,
    input  logic                      coef_we,
    input  logic                      coef_bank,
    input  logic [$clog2(TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]  coef_data,
    output logic signed [ACC_W-1:0]   data_out,
    output logic                      data_out_flag
);

    localparam int TAP_W  = $clog2(TAPS);
    localparam int CNT_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DECIM - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MAC  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic signed [DATA_W-1:0]  r_shift [TAPS];
    logic signed [COEF_W-1:0]  r_coef0 [TAPS];
    logic signed [COEF_W-1:0]  r_coef1 [TAPS];
    logic [CNT_W-1:0]          r_dec_cnt;
    logic [TAP_W-1:0]          r_tap;
    logic                      r_bank;
    logic signed [ACC_W-1:0]   r_acc;

    logic                      w_accept;
    logic                      w_trigger;
    logic                      w_last_tap;
    logic                      w_coef_wr;
    logic signed [COEF_W-1:0]  w_coef;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;

    // Power-on coefficients: the 8-tap wavelet pair, zero for any other length
    function automatic logic signed [COEF_W-1:0] f_rst_coef(input logic bank, input int idx);
        int v;
        v = 0;
        if (TAPS == 8) begin
            case (idx)
                0: v = bank ? -59  : -3;
                1: v = bank ? 183  : 8;
                2: v = bank ? -162 : 8;
                3: v = bank ? -7   : -48;
                4: v = bank ? 48   : -7;
                5: v = bank ? 8    : 162;
                6: v = bank ? -8   : 183;
                7: v = bank ? -3   : 59;
                default: v = 0;
            endcase
        end
        return COEF_W'(v);
    endfunction

    // Samples only enter in IDLE; clear wins over a simultaneous accept
    assign in_ready   = (r_state == S_IDLE);
    assign w_accept   = data_in_ready && in_ready && !clear;
    assign w_trigger  = w_accept && (r_dec_cnt == LAST_CNT);
    assign w_last_tap = (r_tap == LAST_TAP);
    assign w_coef_wr  = coef_we && (r_state == S_IDLE) && !clear;

    assign w_coef     = r_bank ? r_coef1[r_tap] : r_coef0[r_tap];
    assign w_prod     = r_shift[r_tap] * w_coef;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start MAC on a trigger, leave after the last tap or on clear
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (clear || w_last_tap) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Delay line and decimation phase
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_shift[i] <= '0;
            end
            r_dec_cnt <= '0;
        end else if (clear) begin
            for (int i = 0; i < TAPS; i++) begin
                r_shift[i] <= '0;
            end
            r_dec_cnt <= '0;
        end else if (w_accept) begin
            r_shift[0] <= data_in;
            for (int i = 1; i < TAPS; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
            r_dec_cnt <= (r_dec_cnt == LAST_CNT) ? '0 : r_dec_cnt + CNT_W'(1);
        end
    end

    // Coefficient banks; writes land only while idle so a running sum never sees a mix
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef0[i] <= f_rst_coef(1'b0, i);
                r_coef1[i] <= f_rst_coef(1'b1, i);
            end
        end else if (w_coef_wr) begin
            if (coef_bank) begin
                r_coef1[coef_addr] <= coef_data;
            end else begin
                r_coef0[coef_addr] <= coef_data;
            end
        end
    end

    // MAC sequencing: one tap per cycle, result and flag published with the last tap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bank        <= 1'b0;
            r_tap         <= '0;
            r_acc         <= '0;
            data_out      <= '0;
            data_out_flag <= 1'b0;
        end else begin
            data_out_flag <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_bank <= mode;
                        r_tap  <= '0;
                        r_acc  <= '0;
                    end
                end
                S_MAC: begin
                    if (!clear) begin
                        r_acc <= w_sum;
                        r_tap <= r_tap + TAP_W'(1);
                        if (w_last_tap) begin
                            data_out      <= w_sum;
                            data_out_flag <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tap <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wavelet_fir_dec.sv
// tb/tb_wavelet_fir_dec.sv - directed self-checking bench for wavelet_fir_dec
`timescale 1ns/1ps
module tb_wavelet_fir_dec;

    logic               clk;
    logic               reset;
    logic signed [15:0] data_in;
    logic               data_in_ready;
    logic               in_ready;
    logic               mode;
    logic               clear;
    logic               coef_we;
    logic               coef_bank;
    logic [2:0]         coef_addr;
    logic signed [8:0]  coef_data;
    logic signed [27:0] data_out;
    logic               data_out_flag;

    int vectors;
    int miscompares;
    int n;
    int early;
    logic signed [27:0] got [$];

    wavelet_fir_dec dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_in_ready (data_in_ready),
        .in_ready      (in_ready),
        .mode          (mode),
        .clear         (clear),
        .coef_we       (coef_we),
        .coef_bank     (coef_bank),
        .coef_addr     (coef_addr),
        .coef_data     (coef_data),
        .data_out      (data_out),
        .data_out_flag (data_out_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every published result
    always @(negedge clk) begin
        if (reset && data_out_flag) got.push_back(data_out);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] v);
        int w;
        w = 0;
        data_in       = v;
        data_in_ready = 1'b1;
        while (in_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        if (w >= 40) chk("send_ready", in_ready, 1);
        step();
        data_in_ready = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic impulse();
        send(16'sd1);
        repeat (7) send(16'sd0);
        repeat (12) step();
    endtask

    task automatic write_coef(input logic bank, input logic [2:0] addr, input logic signed [8:0] val);
        coef_we   = 1'b1;
        coef_bank = bank;
        coef_addr = addr;
        coef_data = val;
        step();
        coef_we   = 1'b0;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        data_in       = '0;
        data_in_ready = 1'b0;
        mode          = 1'b0;
        clear         = 1'b0;
        coef_we       = 1'b0;
        coef_bank     = 1'b0;
        coef_addr     = '0;
        coef_data     = '0;
        repeat (3) step();
        chk("rst_data_out", data_out, 0);
        chk("rst_flag", data_out_flag, 0);
        reset = 1'b1;
        step();
        chk("rst_in_ready", in_ready, 1);

        // 1. impulse, high-pass then low-pass
        mode = 1'b1;
        got.delete();
        impulse();
        chk("t1_hp_count", got.size(), 4);
        chk("t1_hp_0", got[0], 183);
        chk("t1_hp_1", got[1], -7);
        chk("t1_hp_2", got[2], 8);
        chk("t1_hp_3", got[3], -3);
        do_clear();
        mode = 1'b0;
        got.delete();
        impulse();
        chk("t1_lp_count", got.size(), 4);
        chk("t1_lp_0", got[0], 8);
        chk("t1_lp_1", got[1], -48);
        chk("t1_lp_2", got[2], 162);
        chk("t1_lp_3", got[3], 59);

        // 2. full-scale negative input
        do_clear();
        mode = 1'b0;
        got.delete();
        repeat (16) send(-16'sd32768);
        repeat (12) step();
        chk("t2_lp_count", got.size(), 8);
        chk("t2_lp_4th", got[3], -11862016);
        chk("t2_lp_8th", got[7], -11862016);
        do_clear();
        mode = 1'b1;
        got.delete();
        repeat (16) send(-16'sd32768);
        repeat (12) step();
        chk("t2_hp_4th", got[3], 0);
        chk("t2_hp_8th", got[7], 0);

        // 3. latency and held handshake
        do_clear();
        mode = 1'b0;
        send(16'sd1);
        data_in       = 16'sd5;
        data_in_ready = 1'b1;
        chk("t3_ready_pre", in_ready, 1);
        step();
        data_in = 16'sd7;
        n     = 0;
        early = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            if (data_out_flag) early = 1;
            step();
            n++;
        end
        chk("t3_busy_cycles", n, 8);
        chk("t3_no_early_flag", early, 0);
        chk("t3_flag", data_out_flag, 1);
        chk("t3_out", data_out, -7);
        step();
        data_in_ready = 1'b0;
        chk("t3_flag_width", data_out_flag, 0);
        chk("t3_ready_after", in_ready, 1);
        send(16'sd0);
        repeat (10) step();
        chk("t3_second", data_out, 48);

        // 4. coefficient write in IDLE kept, write during MAC dropped
        write_coef(1'b1, 3'd1, 9'sd100);
        do_clear();
        mode = 1'b1;
        got.delete();
        send(16'sd1);
        send(16'sd0);
        write_coef(1'b1, 3'd1, 9'sd55);
        repeat (10) step();
        chk("t4_count", got.size(), 1);
        chk("t4_out", got[0], 100);

        // 5. clear aborts MAC; clear beats a simultaneous sample
        do_clear();
        mode = 1'b0;
        got.delete();
        send(16'sd1);
        send(16'sd0);
        repeat (4) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t5_ready", in_ready, 1);
        chk("t5_flag", data_out_flag, 0);
        chk("t5_hold", data_out, 100);
        repeat (10) step();
        chk("t5_no_flag", got.size(), 0);
        data_in       = 16'sd9;
        data_in_ready = 1'b1;
        clear         = 1'b1;
        step();
        clear         = 1'b0;
        data_in_ready = 1'b0;
        send(16'sd1);
        chk("t5_one_fresh", in_ready, 1);
        send(16'sd0);
        repeat (10) step();
        chk("t5_count", got.size(), 1);
        chk("t5_out", got[0], 8);

        // 6. reset mid-MAC restores everything
        do_clear();
        mode = 1'b1;
        send(16'sd1);
        send(16'sd0);
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("t6_rst_out", data_out, 0);
        chk("t6_rst_flag", data_out_flag, 0);
        repeat (2) step();
        reset = 1'b1;
        step();
        mode = 1'b1;
        got.delete();
        impulse();
        chk("t6_count", got.size(), 4);
        chk("t6_0", got[0], 183);
        chk("t6_1", got[1], -7);
        chk("t6_2", got[2], 8);
        chk("t6_3", got[3], -3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
